sin_poly_eval: RTL

- Iterative fixed-point sine evaluator for the sin datapath.
- Takes an unsigned full-turn phase and folds it to the first quadrant.
- Evaluates an odd 7th-order minimax polynomial by Horner's method, sharing one instance of the team's 19x19 signed combinational multiplier (37-bit product).
- Feeds operands to that multiplier and consumes its products each cycle, returning a signed Q1.16 sine with a valid/ready handshake.

---
 rtl/sin_poly_eval.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sin_poly_eval.sv
// sin_poly_eval
//   Iterative fixed-point sine evaluator. An unsigned full-turn phase is folded
//   into the first quadrant and an odd 7th-order polynomial is evaluated by
//   Horner's method on x^2. A single 19x19 signed multiplier is shared across
//   the five evaluation states, so one result is produced every 6 cycles.
//
//   State | meaning
//   ------+------------------------------------------------
//   IDLE  | waiting for a phase; In_Ready=1
//   X2    | x2 <= rnd(x*x)
//   P7    | t  <= rnd(C7*x2) + C5
//   P5    | t  <= rnd(t*x2)  + C3
//   P3    | t  <= rnd(t*x2)  + C1
//   P1    | Result <= clamp(+/- rnd(t*x)), Out_Valid pulse
//
// Ports:
//   Clk        system clock, rising edge
//   nReset     synchronous reset, active low
//   Phase      unsigned phase, 2^18 = one full turn (sampled on accept only)
//   In_Valid   Phase valid this cycle
//   In_Ready   high in IDLE only
//   Result     signed Q1.16 sine, clamped to [-65536, +65536]
//   Out_Valid  one-cycle pulse when Result updates

module sin_poly_eval_mul19 (
    input  logic signed [18:0] a,
    input  logic signed [18:0] b,
    output logic signed [36:0] p
);
    assign p = a * b;
endmodule

module sin_poly_eval (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [17:0] Phase,
    input  logic        In_Valid,
    output logic        In_Ready,
    output logic [17:0] Result,
    output logic        Out_Valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_X2   = 3'd1;
    localparam logic [2:0] S_P7   = 3'd2;
    localparam logic [2:0] S_P5   = 3'd3;
    localparam logic [2:0] S_P3   = 3'd4;
    localparam logic [2:0] S_P1   = 3'd5;

    localparam logic signed [18:0] C1 =  19'sd102944;
    localparam logic signed [18:0] C3 = -19'sd42334;
    localparam logic signed [18:0] C5 =  19'sd5223;
    localparam logic signed [18:0] C7 = -19'sd307;

    localparam logic signed [18:0] POS_ONE =  19'sd65536;
    localparam logic signed [18:0] NEG_ONE = -19'sd65536;

    logic [2:0]         state;
    logic signed [18:0] x;
    logic signed [18:0] x2;
    logic signed [18:0] t;
    logic               neg;

    logic signed [18:0] mul_a;
    logic signed [18:0] mul_b;
    logic signed [36:0] mul_p;
    logic signed [36:0] mul_sum;
    logic signed [18:0] mul_rnd;

    logic [18:0]        x_fold;
    logic signed [18:0] y_sgn;
    logic signed [18:0] y_clamp;
    logic               unused_bits;

    assign In_Ready = (state == S_IDLE);

    // Quadrants 1 and 3 mirror the fraction so x always lies in [0, 1.0].
    assign x_fold = Phase[16] ? (19'd65536 - {3'b000, Phase[15:0]})
                              : {3'b000, Phase[15:0]};

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_X2: begin
                mul_a = x;
                mul_b = x;
            end
            S_P7: begin
                mul_a = C7;
                mul_b = x2;
            end
            S_P5, S_P3: begin
                mul_a = t;
                mul_b = x2;
            end
            S_P1: begin
                mul_a = t;
                mul_b = x;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    sin_poly_eval_mul19 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Q4.32 product back to Q2.16, round half up. Bits above 34 are sign
    // copies because no intermediate can overflow 19 bits.
    assign mul_sum = mul_p + 37'sd32768;
    assign mul_rnd = mul_sum[34:16];

    assign y_sgn = neg ? -mul_rnd : mul_rnd;

    always_comb begin
        y_clamp = y_sgn;
        if (y_sgn > POS_ONE)
            y_clamp = POS_ONE;
        else if (y_sgn < NEG_ONE)
            y_clamp = NEG_ONE;
    end

    assign unused_bits = ^{mul_sum[36:35], mul_sum[15:0], y_clamp[18]};

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state     <= S_IDLE;
            x         <= '0;
            x2        <= '0;
            t         <= '0;
            neg       <= 1'b0;
            Result    <= '0;
            Out_Valid <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (In_Valid) begin
                        x     <= $signed(x_fold);
                        neg   <= Phase[17];
                        state <= S_X2;
                    end
                end
                S_X2: begin
                    x2    <= mul_rnd;
                    state <= S_P7;
                end
                S_P7: begin
                    t     <= mul_rnd + C5;
                    state <= S_P5;
                end
                S_P5: begin
                    t     <= mul_rnd + C3;
                    state <= S_P3;
                end
                S_P3: begin
                    t     <= mul_rnd + C1;
                    state <= S_P1;
                end
                S_P1: begin
                    Result    <= y_clamp[17:0];
                    Out_Valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
